clock_display_ctrl: RTL and testbench

CLOCK_DISPLAY_CTRL -- requirements
Module: clock_display_ctrl

---
 rtl/clock_disp_pkg.sv | 44 ++++
 rtl/seg7_encode.sv | 22 ++
 rtl/clock_display_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_clock_display_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_disp_pkg.sv
// Shared constants for the multiplexed clock display: segment patterns, digit positions
// and the binary-to-BCD helper.
package clock_disp_pkg;

   // Segment bit order {dp,g,f,e,d,c,b,a}, active high.
   localparam logic [7:0] SEG_DIGIT [0:9] = '{
      8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
   };
   localparam logic [7:0] SEG_DASH  = 8'h40;
   localparam logic [7:0] SEG_BLANK = 8'h00;

   // Display digit indices, 7 = leftmost, for the "hh-mm-ss" layout.
   localparam logic [2:0] DIG_S0   = 3'd0;
   localparam logic [2:0] DIG_S1   = 3'd1;
   localparam logic [2:0] DIG_SEP0 = 3'd2;
   localparam logic [2:0] DIG_M0   = 3'd3;
   localparam logic [2:0] DIG_M1   = 3'd4;
   localparam logic [2:0] DIG_SEP1 = 3'd5;
   localparam logic [2:0] DIG_H0   = 3'd6;
   localparam logic [2:0] DIG_H1   = 3'd7;

   // Display digit indices for the right-aligned "hhmmss" layout.
   localparam logic [2:0] DIGN_S0 = 3'd0;
   localparam logic [2:0] DIGN_S1 = 3'd1;
   localparam logic [2:0] DIGN_M0 = 3'd2;
   localparam logic [2:0] DIGN_M1 = 3'd3;
   localparam logic [2:0] DIGN_H0 = 3'd4;
   localparam logic [2:0] DIGN_H1 = 3'd5;

   typedef struct packed {
      logic [3:0] code;
      logic       blank;
      logic       dash;
   } digit_t;

   localparam digit_t DIGIT_OFF  = '{code: 4'd0, blank: 1'b1, dash: 1'b0};
   localparam digit_t DIGIT_DASH = '{code: 4'd0, blank: 1'b0, dash: 1'b1};

   // Packs a 0..63 value as {tens, ones}.
   function automatic logic [7:0] bin2bcd(input logic [5:0] v);
      return {4'(v / 6'd10), 4'(v % 6'd10)};
   endfunction

endpackage

// File: rtl/seg7_encode.sv
// Maps one display digit (BCD code plus blank/dash flags) onto 7-segment drive.
module seg7_encode
   import clock_disp_pkg::*;
(
   input  logic [3:0] code_i,
   input  logic       blank_i,
   input  logic       dash_i,
   output logic [7:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      if (blank_i) begin
         seg_o = SEG_BLANK;
      end else if (dash_i) begin
         seg_o = SEG_DASH;
      end else if (code_i <= 4'd9) begin
         seg_o = SEG_DIGIT[code_i];
      end
   end

endmodule

// File: rtl/clock_display_ctrl.sv
// Two-bank, 8-digit multiplexed time display with 12/24-hour form and a blinking
// edit cursor.
module clock_display_ctrl
   import clock_disp_pkg::*;
#(
   parameter int unsigned CLK_HZ   = 50_000_000,
   parameter int unsigned SCAN_HZ  = 1000,
   parameter int unsigned BLINK_HZ = 2,
   parameter bit          SEP_EN   = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] hours,
   input  logic [5:0] minutes,
   input  logic [5:0] seconds,
   input  logic [2:0] pos,
   input  logic       set_mod,
   input  logic       mode_12h,
   output logic [3:0] left_wei,
   output logic [3:0] right_wei,
   output logic [7:0] left_duan,
   output logic [7:0] right_duan
);

   localparam int unsigned ScanDiv  = (CLK_HZ / SCAN_HZ > 0) ? CLK_HZ / SCAN_HZ : 1;
   localparam int unsigned HalfDiv  = (CLK_HZ / (2 * BLINK_HZ) > 0) ?
                                      CLK_HZ / (2 * BLINK_HZ) : 1;
   localparam int unsigned ScanW    = (ScanDiv > 1) ? $clog2(ScanDiv) : 1;
   localparam int unsigned BlinkW   = (HalfDiv > 1) ? $clog2(HalfDiv) : 1;
   localparam logic [ScanW-1:0]  ScanLast  = ScanW'(ScanDiv - 1);
   localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(HalfDiv - 1);

   logic [ScanW-1:0]  scan_cnt_q, scan_cnt_d;
   logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
   logic [1:0]        idx_q, idx_d;
   logic              phase_q, phase_d;
   logic [3:0]        wei_q, wei_d;
   logic [7:0]        lduan_q, lduan_d, rduan_q, rduan_d;
   logic [7:0]        hr_bcd_q, hr_bcd_d, min_bcd_q, min_bcd_d, sec_bcd_q, sec_bcd_d;
   logic              h1_blank_q, h1_blank_d;
   logic              scan_tick;
   logic [5:0]        hr_adj;
   digit_t            disp [8];
   digit_t            l_dig, r_dig;
   logic [2:0]        lsel, rsel, edit_dig;
   logic              edit_valid, blink_off;

   // Counters and scan index.
   always_comb begin
      scan_tick  = (scan_cnt_q == ScanLast);
      scan_cnt_d = scan_tick ? '0 : scan_cnt_q + 1'b1;
      idx_d      = scan_tick ? idx_q + 2'd1 : idx_q;
      wei_d      = 4'b0001 << idx_d;

      // Counter parked at 0 outside edit mode so a fresh edit starts a full visible half-period.
      blink_cnt_d = '0;
      phase_d     = 1'b1;
      if (set_mod) begin
         phase_d = phase_q;
         if (blink_cnt_q == BlinkLast) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   // Hour form and BCD conversion.
   always_comb begin
      hr_adj = hours;
      if (mode_12h) begin
         if (hours == 6'd0) begin
            hr_adj = 6'd12;
         end else if (hours >= 6'd13 && hours <= 6'd23) begin
            hr_adj = hours - 6'd12;
         end
      end
      hr_bcd_d   = bin2bcd(hr_adj);
      min_bcd_d  = bin2bcd(minutes);
      sec_bcd_d  = bin2bcd(seconds);
      h1_blank_d = mode_12h && (hr_bcd_d[7:4] == 4'd0);
   end

   // Digit layout and edit cursor position.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         disp[i] = DIGIT_OFF;
      end
      edit_valid = (pos <= 3'd5);
      edit_dig   = pos;
      if (SEP_EN) begin
         disp[DIG_H1]   = '{code: hr_bcd_q[7:4], blank: h1_blank_q, dash: 1'b0};
         disp[DIG_H0]   = '{code: hr_bcd_q[3:0], blank: 1'b0, dash: 1'b0};
         disp[DIG_SEP1] = DIGIT_DASH;
         disp[DIG_M1]   = '{code: min_bcd_q[7:4], blank: 1'b0, dash: 1'b0};
         disp[DIG_M0]   = '{code: min_bcd_q[3:0], blank: 1'b0, dash: 1'b0};
         disp[DIG_SEP0] = DIGIT_DASH;
         disp[DIG_S1]   = '{code: sec_bcd_q[7:4], blank: 1'b0, dash: 1'b0};
         disp[DIG_S0]   = '{code: sec_bcd_q[3:0], blank: 1'b0, dash: 1'b0};
         case (pos)
            3'd0:    edit_dig = DIG_S0;
            3'd1:    edit_dig = DIG_S1;
            3'd2:    edit_dig = DIG_M0;
            3'd3:    edit_dig = DIG_M1;
            3'd4:    edit_dig = DIG_H0;
            3'd5:    edit_dig = DIG_H1;
            default: edit_dig = DIG_S0;
         endcase
      end else begin
         disp[DIGN_H1] = '{code: hr_bcd_q[7:4], blank: h1_blank_q, dash: 1'b0};
         disp[DIGN_H0] = '{code: hr_bcd_q[3:0], blank: 1'b0, dash: 1'b0};
         disp[DIGN_M1] = '{code: min_bcd_q[7:4], blank: 1'b0, dash: 1'b0};
         disp[DIGN_M0] = '{code: min_bcd_q[3:0], blank: 1'b0, dash: 1'b0};
         disp[DIGN_S1] = '{code: sec_bcd_q[7:4], blank: 1'b0, dash: 1'b0};
         disp[DIGN_S0] = '{code: sec_bcd_q[3:0], blank: 1'b0, dash: 1'b0};
      end
   end

   // Bank bit 0 is the leftmost digit, so scan index k selects digit 7-k / 3-k.
   always_comb begin
      lsel      = {1'b1, ~idx_d};
      rsel      = {1'b0, ~idx_d};
      blink_off = set_mod && !phase_d && edit_valid;
      l_dig     = disp[lsel];
      r_dig     = disp[rsel];
      if (blink_off && edit_dig == lsel) begin
         l_dig.blank = 1'b1;
      end
      if (blink_off && edit_dig == rsel) begin
         r_dig.blank = 1'b1;
      end
   end

   seg7_encode u_left_enc (
      .code_i  (l_dig.code),
      .blank_i (l_dig.blank),
      .dash_i  (l_dig.dash),
      .seg_o   (lduan_d)
   );

   seg7_encode u_right_enc (
      .code_i  (r_dig.code),
      .blank_i (r_dig.blank),
      .dash_i  (r_dig.dash),
      .seg_o   (rduan_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt_q  <= '0;
         blink_cnt_q <= '0;
         idx_q       <= 2'd0;
         phase_q     <= 1'b1;
         wei_q       <= 4'b0001;
         lduan_q     <= SEG_BLANK;
         rduan_q     <= SEG_BLANK;
         hr_bcd_q    <= 8'h00;
         min_bcd_q   <= 8'h00;
         sec_bcd_q   <= 8'h00;
         h1_blank_q  <= 1'b0;
      end else begin
         scan_cnt_q  <= scan_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         idx_q       <= idx_d;
         phase_q     <= phase_d;
         wei_q       <= wei_d;
         lduan_q     <= lduan_d;
         rduan_q     <= rduan_d;
         hr_bcd_q    <= hr_bcd_d;
         min_bcd_q   <= min_bcd_d;
         sec_bcd_q   <= sec_bcd_d;
         h1_blank_q  <= h1_blank_d;
      end
   end

   assign left_wei   = wei_q;
   assign right_wei  = wei_q;
   assign left_duan  = lduan_q;
   assign right_duan = rduan_q;

endmodule

// File: tb/tb_clock_display_ctrl.sv
// Directed bench: table of time values with hand-computed segment patterns, plus
// blink-cursor and reset sequences.
module tb_clock_display_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] hours, minutes, seconds;
   logic [2:0] pos;
   logic       set_mod, mode_12h;
   logic [3:0] left_wei, right_wei, left_wei0, right_wei0;
   logic [7:0] left_duan, right_duan, left_duan0, right_duan0;

   int checks = 0;
   int errors = 0;
   int cyc;
   int sm_edges;

   always #5 clk = ~clk;

   clock_display_ctrl #(
      .CLK_HZ   (1000),
      .SCAN_HZ  (250),
      .BLINK_HZ (4),
      .SEP_EN   (1'b1)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .hours      (hours),
      .minutes    (minutes),
      .seconds    (seconds),
      .pos        (pos),
      .set_mod    (set_mod),
      .mode_12h   (mode_12h),
      .left_wei   (left_wei),
      .right_wei  (right_wei),
      .left_duan  (left_duan),
      .right_duan (right_duan)
   );

   clock_display_ctrl #(
      .CLK_HZ   (1000),
      .SCAN_HZ  (250),
      .BLINK_HZ (4),
      .SEP_EN   (1'b0)
   ) u_dut_nosep (
      .clk        (clk),
      .rst        (rst),
      .hours      (hours),
      .minutes    (minutes),
      .seconds    (seconds),
      .pos        (pos),
      .set_mod    (set_mod),
      .mode_12h   (mode_12h),
      .left_wei   (left_wei0),
      .right_wei  (right_wei0),
      .left_duan  (left_duan0),
      .right_duan (right_duan0)
   );

   // Edges since reset release and edges spent in edit mode; scan index and blink phase
   // follow from these directly.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc      <= 0;
         sm_edges <= 0;
      end else begin
         cyc      <= cyc + 1;
         sm_edges <= set_mod ? sm_edges + 1 : 0;
      end
   end

   typedef struct {
      logic [5:0]  h;
      logic [5:0]  m;
      logic [5:0]  s;
      logic        m12;
      logic [31:0] el;
      logic [31:0] er;
      logic        chk0;
      logic [31:0] el0;
      logic [31:0] er0;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs n cycles checking every output; bdig is the display digit under a blinking
   // cursor (-1 = none).
   task automatic run_chk(input string name, input int n, input logic [31:0] el,
                          input logic [31:0] er, input int bdig, input logic chk0,
                          input logic [31:0] el0, input logic [31:0] er0);
      int         idx;
      bit         phase;
      logic [7:0] exp_l, exp_r, exp_w;
      for (int k = 0; k < n; k++) begin
         step();
         if (cyc >= 2) begin
            idx   = (cyc / 4) % 4;
            phase = !set_mod || ((sm_edges / 125) % 2 == 0);
            exp_w = 8'd1 << idx;
            exp_l = el[31 - 8 * idx -: 8];
            exp_r = er[31 - 8 * idx -: 8];
            if (!phase && bdig == 7 - idx) exp_l = 8'h00;
            if (!phase && bdig == 3 - idx) exp_r = 8'h00;
            chk({name, " left_wei"}, {4'd0, left_wei}, exp_w);
            chk({name, " right_wei"}, {4'd0, right_wei}, exp_w);
            chk({name, " left_duan"}, left_duan, exp_l);
            chk({name, " right_duan"}, right_duan, exp_r);
            if (chk0) begin
               chk({name, " nosep left_duan"}, left_duan0, el0[31 - 8 * idx -: 8]);
               chk({name, " nosep right_duan"}, right_duan0, er0[31 - 8 * idx -: 8]);
            end
         end
      end
   endtask

   task automatic chk_reset_state(input string name);
      chk({name, " left_wei"}, {4'd0, left_wei}, 8'h01);
      chk({name, " right_wei"}, {4'd0, right_wei}, 8'h01);
      chk({name, " left_duan"}, left_duan, 8'h00);
      chk({name, " right_duan"}, right_duan, 8'h00);
      chk({name, " nosep left_duan"}, left_duan0, 8'h00);
      chk({name, " nosep right_duan"}, right_duan0, 8'h00);
   endtask

   initial begin
      vecs[0] = '{6'd12, 6'd34, 6'd56, 1'b0, 32'h065B404F, 32'h66406D7D, 1'b0, 32'h0, 32'h0};
      vecs[1] = '{6'd0,  6'd7,  6'd9,  1'b1, 32'h065B403F, 32'h07403F6F, 1'b0, 32'h0, 32'h0};
      vecs[2] = '{6'd7,  6'd59, 6'd30, 1'b1, 32'h0007406D, 32'h6F404F3F, 1'b0, 32'h0, 32'h0};
      vecs[3] = '{6'd23, 6'd0,  6'd0,  1'b1, 32'h0606403F, 32'h3F403F3F, 1'b0, 32'h0, 32'h0};
      vecs[4] = '{6'd63, 6'd63, 6'd63, 1'b0, 32'h7D4F407D, 32'h4F407D4F, 1'b0, 32'h0, 32'h0};
      vecs[5] = '{6'd13, 6'd45, 6'd8,  1'b0, 32'h064F4066, 32'h6D403F7F, 1'b0, 32'h0, 32'h0};
      vecs[6] = '{6'd0,  6'd0,  6'd0,  1'b0, 32'h3F3F403F, 32'h3F403F3F, 1'b0, 32'h0, 32'h0};
      vecs[7] = '{6'd24, 6'd10, 6'd1,  1'b1, 32'h5B664006, 32'h3F403F06, 1'b0, 32'h0, 32'h0};
      vecs[8] = '{6'd12, 6'd0,  6'd0,  1'b1, 32'h065B403F, 32'h3F403F3F, 1'b0, 32'h0, 32'h0};
      vecs[9] = '{6'd63, 6'd0,  6'd9,  1'b0, 32'h7D4F403F, 32'h3F403F6F,
                  1'b1, 32'h00007D4F, 32'h3F3F3F6F};

      rst      = 1'b1;
      hours    = 6'd12;
      minutes  = 6'd34;
      seconds  = 6'd56;
      pos      = 3'd7;
      set_mod  = 1'b0;
      mode_12h = 1'b0;
      repeat (3) step();
      chk_reset_state("reset");

      // Release with 12:34:56 applied and follow one full scan.
      rst = 1'b0;
      run_chk("post_reset", 17, vecs[0].el, vecs[0].er, -1, 1'b0, 32'h0, 32'h0);

      foreach (vecs[i]) begin
         hours    = vecs[i].h;
         minutes  = vecs[i].m;
         seconds  = vecs[i].s;
         mode_12h = vecs[i].m12;
         repeat (20) step();
         run_chk($sformatf("vec%0d", i), 16, vecs[i].el, vecs[i].er, -1,
                 vecs[i].chk0, vecs[i].el0, vecs[i].er0);
      end

      // Edit cursor on hour ones (display digit 6).
      hours    = 6'd12;
      minutes  = 6'd34;
      seconds  = 6'd56;
      mode_12h = 1'b0;
      repeat (20) step();
      pos     = 3'd4;
      set_mod = 1'b1;
      run_chk("blink_h0", 400, vecs[0].el, vecs[0].er, 6, 1'b0, 32'h0, 32'h0);

      // Cursor moves to seconds ones mid-blank; phase carries on.
      pos = 3'd0;
      run_chk("blink_s0", 150, vecs[0].el, vecs[0].er, 0, 1'b0, 32'h0, 32'h0);

      pos = 3'd7;
      run_chk("blink_none", 150, vecs[0].el, vecs[0].er, -1, 1'b0, 32'h0, 32'h0);

      // One-cycle reset pulse while the blink phase is off.
      pos = 3'd4;
      while (((sm_edges / 125) % 2) == 0) step();
      rst = 1'b1;
      #1;
      chk_reset_state("mid_reset");
      step();
      chk_reset_state("mid_reset_held");
      rst = 1'b0;
      run_chk("after_reset", 60, vecs[0].el, vecs[0].er, 6, 1'b0, 32'h0, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
